// File: rtl/lea_ser_pkg.sv
// Shared LEA serializer definitions: FSM state type, lane-count helper and the
// block/byte widths used across the LEA datapath blocks.
package lea_ser_pkg;

  localparam int LEA_BLOCK_W = 128;
  localparam int LEA_BYTE_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  function automatic int lanes(input int din_w, input int lane_w);
    return din_w / lane_w;
  endfunction

endpackage

// File: rtl/lea_block_serializer_if.sv
// Block-in / lane-out handshake bundle for lea_block_serializer.
// slave = serializer side, master = block producer plus lane consumer.
interface lea_block_serializer_if #(
  parameter int DIN_W  = lea_ser_pkg::LEA_BLOCK_W,
  parameter int LANE_W = lea_ser_pkg::LEA_BYTE_W
) ();
  import lea_ser_pkg::*;

  localparam int LANES = lanes(DIN_W, LANE_W);
  localparam int IDX_W = $clog2(LANES);

  logic [DIN_W-1:0]  Din;
  logic              din_valid;
  logic              din_ready;
  logic              msb_first;
  logic [LANE_W-1:0] Dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic [IDX_W-1:0]  dout_idx;

  modport slave (
    input  Din, din_valid, msb_first, dout_ready,
    output din_ready, Dout, dout_valid, dout_last, dout_idx
  );

  modport master (
    output Din, din_valid, msb_first, dout_ready,
    input  din_ready, Dout, dout_valid, dout_last, dout_idx
  );

endinterface

// File: rtl/lea_lane_mux.sv
// Combinational lane selector: picks lane sel out of a DIN_W-bit word.
// An out-of-range sel (only possible when LANES is not a power of two) yields 0.
module lea_lane_mux
  import lea_ser_pkg::*;
#(
  parameter  int DIN_W  = LEA_BLOCK_W,
  parameter  int LANE_W = LEA_BYTE_W,
  localparam int LANES  = lanes(DIN_W, LANE_W),
  localparam int IDX_W  = $clog2(LANES)
) (
  input  logic [DIN_W-1:0]  din,
  input  logic [IDX_W-1:0]  sel,
  output logic [LANE_W-1:0] lane
);

  // one-hot compare per lane, OR-free priority-less select
  always_comb begin
    lane = '0;
    for (int k = 0; k < LANES; k++) begin
      if (sel == IDX_W'(k)) lane = din[k*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/lea_block_serializer.sv
// LEA block serializer: accepts one DIN_W-bit block, emits LANES lanes of
// LANE_W bits, lane order chosen per block by msb_first.
// Optional macro LEA_SER_PIPE_EN: accept the next block on the last-beat edge
// (zero bubble); default build returns to IDLE for one cycle between blocks.
//
// state | meaning
// IDLE  | no block held; din_ready high once out of reset
// SHIFT | block held; presenting lane cnt, one lane per accepted beat
module lea_block_serializer
  import lea_ser_pkg::*;
#(
  parameter int DIN_W  = LEA_BLOCK_W,
  parameter int LANE_W = LEA_BYTE_W
) (
  input logic                   clk,
  input logic                   rst_n,
  lea_block_serializer_if.slave bus
);

  localparam int              LANES = lanes(DIN_W, LANE_W);
  localparam int              IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

  ser_state_t        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q;
  logic [DIN_W-1:0]  block_q;
  logic              msb_q;
  logic              rdy_en_q;   // keeps din_ready low until the first edge after reset release

  logic              load, cnt_inc, cnt_clr;
  logic              valid_c, last_c, ready_c, accept, beat;
  logic [IDX_W-1:0]  sel;
  logic [LANE_W-1:0] lane_c;

  // state register and post-reset ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  // block register, latched order and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_q <= '0;
      msb_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      block_q <= bus.Din;
      msb_q   <= bus.msb_first;
      cnt_q   <= '0;
    end else if (cnt_clr) begin
      cnt_q   <= '0;
    end else if (cnt_inc) begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // handshake decode, next state and datapath controls
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;

    valid_c = (state_q == SHIFT);
    last_c  = valid_c && (cnt_q == LAST);
`ifdef LEA_SER_PIPE_EN
    // the only combinational dout_ready -> din_ready path: reload on the last beat
    ready_c = ((state_q == IDLE) && rdy_en_q) || (last_c && bus.dout_ready);
`else
    ready_c = (state_q == IDLE) && rdy_en_q;
`endif
    accept  = bus.din_valid && ready_c;
    beat    = valid_c && bus.dout_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (beat) begin
          if (cnt_q != LAST) begin
            cnt_inc = 1'b1;
          end else begin
`ifdef LEA_SER_PIPE_EN
            if (accept) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              cnt_clr = 1'b1;
            end
`else
            state_d = IDLE;
            cnt_clr = 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // beat number maps to a physical lane according to the latched order
  assign sel = msb_q ? (LAST - cnt_q) : cnt_q;

  lea_lane_mux #(
    .DIN_W  (DIN_W),
    .LANE_W (LANE_W)
  ) u_mux (
    .din  (block_q),
    .sel  (sel),
    .lane (lane_c)
  );

  assign bus.Dout       = lane_c;
  assign bus.dout_valid = valid_c;
  assign bus.dout_last  = last_c;
  assign bus.dout_idx   = cnt_q;
  assign bus.din_ready  = ready_c;

endmodule
